// File: rtl/alt_vipcti131_mode_match_ctrl_if.sv
// Bundle of measurement, mode-table read and match-result signals for the
// clocked-video-input mode matcher; slave is the matcher, master its environment.
interface alt_vipcti131_mode_match_ctrl_if #(
  parameter int NO_OF_MODES      = 3,
  parameter int LOG2_NO_OF_MODES = 2,
  parameter int SAMPLE_WIDTH     = 16,
  parameter int LINE_WIDTH       = 16
);
  logic                        measure_valid;
  logic                        measure_lost;
  logic [SAMPLE_WIDTH-1:0]     measured_samples;
  logic [LINE_WIDTH-1:0]       measured_lines;
  logic                        measured_interlaced;
  logic [NO_OF_MODES-1:0]      mode_valid;
  logic [LOG2_NO_OF_MODES-1:0] mode_rd_addr;
  logic [SAMPLE_WIDTH-1:0]     mode_rd_samples;
  logic [LINE_WIDTH-1:0]       mode_rd_lines;
  logic                        mode_rd_interlaced;
  logic [NO_OF_MODES-1:0]      match_one_hot;
  logic                        match_valid;
  logic                        busy;

  modport slave (
    input  measure_valid, measure_lost, measured_samples, measured_lines,
           measured_interlaced, mode_valid, mode_rd_samples, mode_rd_lines,
           mode_rd_interlaced,
    output mode_rd_addr, match_one_hot, match_valid, busy
  );

  modport master (
    output measure_valid, measure_lost, measured_samples, measured_lines,
           measured_interlaced, mode_valid, mode_rd_samples, mode_rd_lines,
           mode_rd_interlaced,
    input  mode_rd_addr, match_one_hot, match_valid, busy
  );
endinterface

// File: rtl/alt_vipcti131_mode_match_ctrl.sv
// Scans the mode table once per resolution measurement and reports the
// lowest-index matching entry as a registered zero-or-one-hot vector.
module alt_vipcti131_mode_match_ctrl #(
  parameter int NO_OF_MODES      = 3,
  parameter int LOG2_NO_OF_MODES = 2,
  parameter int SAMPLE_WIDTH     = 16,
  parameter int LINE_WIDTH       = 16
) (
  input logic                     clk,
  input logic                     rst,
  alt_vipcti131_mode_match_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

  localparam logic [LOG2_NO_OF_MODES-1:0] LAST_ADDR = LOG2_NO_OF_MODES'(NO_OF_MODES - 1);

  state_t                      state, next_state;
  logic [SAMPLE_WIDTH-1:0]     work_samples, pend_samples;
  logic [LINE_WIDTH-1:0]       work_lines, pend_lines;
  logic                        work_interlaced, pend_interlaced, pend_flag;
  logic                        cmp_pending;
  logic [LOG2_NO_OF_MODES-1:0] cmp_idx;
  logic [NO_OF_MODES-1:0]      hit_vec, entry_sel, entry_onehot, acc_next;
  logic                        fields_eq;
  logic                        accept;
  logic [LOG2_NO_OF_MODES-1:0] addr_next;
  logic [NO_OF_MODES-1:0]      one_hot_next;
  logic                        valid_next, busy_next;

  assign accept = bus.measure_valid && !bus.measure_lost;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (bus.measure_lost) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) next_state = SCAN;
        SCAN:    if (bus.mode_rd_addr == LAST_ADDR) next_state = FLUSH;
        FLUSH:   next_state = DONE;
        DONE:    next_state = (accept || pend_flag) ? SCAN : IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Read data arriving this cycle belongs to the address issued last cycle;
  // an existing hit blocks later ones so the lowest index wins.
  always_comb begin
    fields_eq = (bus.mode_rd_samples == work_samples) &&
                (bus.mode_rd_lines == work_lines) &&
                (bus.mode_rd_interlaced == work_interlaced);
    entry_sel = '0;
    for (int k = 0; k < NO_OF_MODES; k++)
      entry_sel[k] = cmp_pending && (cmp_idx == LOG2_NO_OF_MODES'(k));
    entry_onehot = fields_eq ? (entry_sel & bus.mode_valid) : '0;
    acc_next     = (hit_vec != '0) ? hit_vec : entry_onehot;
  end

  always_comb begin
    addr_next    = '0;
    one_hot_next = bus.match_one_hot;
    valid_next   = 1'b0;
    busy_next    = (next_state != IDLE);
    if (state == SCAN && next_state == SCAN)
      addr_next = bus.mode_rd_addr + 1'b1;
    if (bus.measure_lost) begin
      one_hot_next = '0;
    end else if (state == FLUSH) begin
      one_hot_next = acc_next;
      valid_next   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mode_rd_addr  <= '0;
      bus.match_one_hot <= '0;
      bus.match_valid   <= 1'b0;
      bus.busy          <= 1'b0;
    end else begin
      bus.mode_rd_addr  <= addr_next;
      bus.match_one_hot <= one_hot_next;
      bus.match_valid   <= valid_next;
      bus.busy          <= busy_next;
    end
  end

  // Working fields feed the active scan; a strobe during a scan parks in the
  // one-deep pending slot, and a strobe seen in DONE itself is the newest.
  always_ff @(posedge clk) begin
    if (rst) begin
      work_samples    <= '0;
      work_lines      <= '0;
      work_interlaced <= 1'b0;
      pend_samples    <= '0;
      pend_lines      <= '0;
      pend_interlaced <= 1'b0;
      pend_flag       <= 1'b0;
      cmp_pending     <= 1'b0;
      cmp_idx         <= '0;
      hit_vec         <= '0;
    end else begin
      cmp_pending <= (state == SCAN) && !bus.measure_lost;
      cmp_idx     <= bus.mode_rd_addr;
      if (state == SCAN || state == FLUSH) hit_vec <= acc_next;
      else                                 hit_vec <= '0;
      if (bus.measure_lost) begin
        pend_flag <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              work_samples    <= bus.measured_samples;
              work_lines      <= bus.measured_lines;
              work_interlaced <= bus.measured_interlaced;
            end
          end
          DONE: begin
            if (accept) begin
              work_samples    <= bus.measured_samples;
              work_lines      <= bus.measured_lines;
              work_interlaced <= bus.measured_interlaced;
            end else if (pend_flag) begin
              work_samples    <= pend_samples;
              work_lines      <= pend_lines;
              work_interlaced <= pend_interlaced;
            end
            pend_flag <= 1'b0;
          end
          default: begin
            if (accept) begin
              pend_samples    <= bus.measured_samples;
              pend_lines      <= bus.measured_lines;
              pend_interlaced <= bus.measured_interlaced;
              pend_flag       <= 1'b1;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_alt_vipcti131_mode_match_ctrl.sv
// Scoreboard bench: a transaction-level model predicts each scan result and
// its completion edge; a negedge monitor compares whatever the DUT presents.
module tb_alt_vipcti131_mode_match_ctrl;
  localparam int N  = 3;
  localparam int L  = 2;
  localparam int SW = 16;
  localparam int LW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alt_vipcti131_mode_match_ctrl_if #(.NO_OF_MODES(N), .LOG2_NO_OF_MODES(L),
    .SAMPLE_WIDTH(SW), .LINE_WIDTH(LW)) bus ();

  alt_vipcti131_mode_match_ctrl #(.NO_OF_MODES(N), .LOG2_NO_OF_MODES(L),
    .SAMPLE_WIDTH(SW), .LINE_WIDTH(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int             tab_s[N];
  int             tab_l[N];
  bit             tab_i[N];
  logic [N-1:0]   tab_en;
  assign bus.mode_valid = tab_en;

  // Mode table RAM with one cycle of read latency.
  always @(posedge clk) begin
    bus.mode_rd_samples    <= SW'(tab_s[bus.mode_rd_addr]);
    bus.mode_rd_lines      <= LW'(tab_l[bus.mode_rd_addr]);
    bus.mode_rd_interlaced <= tab_i[bus.mode_rd_addr];
  end

  typedef struct {
    logic [N-1:0] oh;
    int           end_cyc;
  } exp_t;

  exp_t         exp_q[$];
  int           cyc = 0;
  int           n_cmp = 0;
  int           n_err = 0;
  bit           m_busy = 0;
  int           m_start = 0;
  int           m_end = 0;
  bit           m_pend = 0;
  int           p_s, p_l;
  bit           p_i;
  logic [N-1:0] m_onehot = '0;
  logic [N-1:0] m_cur = '0;

  function automatic logic [N-1:0] ref_match(int s, int l, bit i);
    logic [N-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++)
      if (tab_en[k] && tab_s[k] == s && tab_l[k] == l && tab_i[k] == i) begin
        r[k] = 1'b1;
        return r;
      end
    return r;
  endfunction

  function automatic void start_scan(int s, int l, bit i);
    exp_t e;
    m_busy    = 1;
    m_start   = cyc;
    m_end     = cyc + N + 1;
    m_cur     = ref_match(s, l, i);
    e.oh      = m_cur;
    e.end_cyc = m_end;
    exp_q.push_back(e);
  endfunction

  task automatic check_output(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  // Reference model: scan start, completion edge and pending slot by edge count.
  always @(posedge clk) begin
    int s, l;
    bit i, mv;
    cyc++;
    mv = bus.measure_valid;
    s  = int'(bus.measured_samples);
    l  = int'(bus.measured_lines);
    i  = bus.measured_interlaced;
    if (rst) begin
      m_busy = 0; m_pend = 0; m_onehot = '0;
      exp_q.delete();
    end else if (bus.measure_lost) begin
      if (m_busy && cyc <= m_end && exp_q.size() > 0) void'(exp_q.pop_back());
      m_busy = 0; m_pend = 0; m_onehot = '0;
    end else if (!m_busy) begin
      if (mv) start_scan(s, l, i);
    end else if (cyc == m_end) begin
      m_onehot = m_cur;
      if (mv) begin m_pend = 1; p_s = s; p_l = l; p_i = i; end
    end else if (cyc == m_end + 1) begin
      m_busy = 0;
      if (mv)          start_scan(s, l, i);
      else if (m_pend) start_scan(p_s, p_l, p_i);
      m_pend = 0;
    end else if (mv) begin
      m_pend = 1; p_s = s; p_l = l; p_i = i;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (cyc > 0) begin
      check_output("busy", 32'(bus.busy), 32'(m_busy));
      check_output("match_one_hot", 32'(bus.match_one_hot), 32'(m_onehot));
      if (!m_busy)
        check_output("idle_addr", 32'(bus.mode_rd_addr), 32'd0);
      else if (cyc - m_start < N)
        check_output("scan_addr", 32'(bus.mode_rd_addr), 32'(cyc - m_start));
      if (bus.match_valid) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_match_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_output("result_one_hot", 32'(bus.match_one_hot), 32'(e.oh));
          check_output("result_cycle", 32'(cyc), 32'(e.end_cyc));
        end
      end else if (exp_q.size() > 0 && exp_q[0].end_cyc <= cyc) begin
        e = exp_q.pop_front();
        check_output("missing_match_valid", 32'd0, 32'd1);
      end
    end
  end

  task automatic set_fields(int s, int l, bit i);
    bus.measured_samples    = SW'(s);
    bus.measured_lines      = LW'(l);
    bus.measured_interlaced = i;
  endtask

  task automatic apply_stimulus(int s, int l, bit i);
    @(negedge clk);
    set_fields(s, l, i);
    bus.measure_valid = 1'b1;
    @(negedge clk);
    bus.measure_valid = 1'b0;
  endtask

  task automatic set_entry(int k, int s, int l, bit i);
    tab_s[k] = s; tab_l[k] = l; tab_i[k] = i;
  endtask

  task automatic wait_cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int k;
    bus.measure_valid = 1'b0;
    bus.measure_lost  = 1'b0;
    set_fields(0, 0, 1'b0);
    set_entry(0, 720, 480, 1'b1);
    set_entry(1, 1280, 720, 1'b0);
    set_entry(2, 1920, 1080, 1'b0);
    tab_en = 3'b111;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(2);

    $display("[TB] single match");
    apply_stimulus(1280, 720, 1'b0);
    wait_cycles(8);

    $display("[TB] priority and enable");
    set_entry(0, 1920, 1080, 1'b0);
    apply_stimulus(1920, 1080, 1'b0);
    wait_cycles(8);
    tab_en = 3'b110;
    apply_stimulus(1920, 1080, 1'b0);
    wait_cycles(8);
    apply_stimulus(640, 480, 1'b0);
    wait_cycles(8);

    $display("[TB] pending measurements");
    set_entry(0, 720, 480, 1'b1);
    tab_en = 3'b111;
    @(negedge clk); set_fields(720, 480, 1'b1); bus.measure_valid = 1'b1;
    @(negedge clk); bus.measure_valid = 1'b0;
    @(negedge clk); set_fields(1920, 1080, 1'b0); bus.measure_valid = 1'b1;
    @(negedge clk); set_fields(1280, 720, 1'b0);
    @(negedge clk); bus.measure_valid = 1'b0;
    wait_cycles(14);

    $display("[TB] loss during flush and with strobe");
    apply_stimulus(1280, 720, 1'b0);
    wait_cycles(3);
    bus.measure_lost = 1'b1;
    @(negedge clk); bus.measure_lost = 1'b0;
    wait_cycles(4);
    @(negedge clk); set_fields(720, 480, 1'b1);
    bus.measure_valid = 1'b1; bus.measure_lost = 1'b1;
    @(negedge clk); bus.measure_valid = 1'b0; bus.measure_lost = 1'b0;
    wait_cycles(8);

    $display("[TB] reset mid-scan");
    apply_stimulus(720, 480, 1'b1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    wait_cycles(2);
    apply_stimulus(1920, 1080, 1'b0);
    wait_cycles(8);

    $display("[TB] randomized traffic");
    for (int ph = 0; ph < 6; ph++) begin
      @(negedge clk); bus.measure_lost = 1'b1;
      @(negedge clk); bus.measure_lost = 1'b0;
      for (int e = 0; e < N; e++)
        set_entry(e, 100 * int'($urandom_range(1, 3)), 50 + 10 * int'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
      tab_en = N'($urandom);
      for (int c = 0; c < 150; c++) begin
        @(negedge clk);
        k = int'($urandom_range(0, N));
        if (k < N) set_fields(tab_s[k], tab_l[k], tab_i[k]);
        else       set_fields(100 * int'($urandom_range(1, 3)), 50, 1'($urandom_range(0, 1)));
        bus.measure_valid = ($urandom_range(0, 3) == 0);
        bus.measure_lost  = ($urandom_range(0, 59) == 0);
      end
      @(negedge clk);
      bus.measure_valid = 1'b0; bus.measure_lost = 1'b0;
      wait_cycles(12);
    end

    wait_cycles(10);
    check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
